// File: rtl/t01_drop_pacer.sv
// Drop pacer: turns game-tick divider pulses into a req/ack drop handshake,
// derives the divider's scoremod from cleared lines and speed_up from the soft-drop button.
module t01_drop_pacer #(
    parameter int unsigned LINES_PER_LEVEL = 10,
    parameter int unsigned MAX_LEVEL       = 15,
    parameter int unsigned LEVEL_STEP      = 500000,
    parameter int unsigned DEBOUNCE        = 250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_n,
    input  logic        new_game,
    input  logic        game_over,
    input  logic        lines_valid,
    input  logic [2:0]  lines_cleared,
    input  logic        down_btn,
    input  logic        drop_ack,
    output logic [24:0] scoremod,
    output logic        speed_up,
    output logic [3:0]  level,
    output logic        drop_req,
    output logic        overrun
);

    localparam logic [4:0]  LPL  = 5'(LINES_PER_LEVEL);
    localparam logic [3:0]  MAXL = 4'(MAX_LEVEL);
    localparam logic [24:0] STEP = 25'(LEVEL_STEP);
    localparam int unsigned CW   = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t        state;
    logic          tick_prev;
    logic          tick_ev;
    logic          pending;
    logic [3:0]    sub;
    logic [2:0]    n_lines;
    logic [4:0]    sum;
    logic          sync1;
    logic          sync2;
    logic [CW-1:0] db_cnt;

    // tick_prev resets low so the divider's reset-low newclk is not seen as a falling edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_prev <= 1'b0;
            tick_ev   <= 1'b0;
        end else begin
            tick_prev <= tick_n;
            tick_ev   <= tick_prev & ~tick_n;
        end
    end

    always_comb begin
        n_lines = (lines_cleared > 3'd4) ? 3'd4 : lines_cleared;
        sum     = {1'b0, sub} + {2'b00, n_lines};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level    <= '0;
            sub      <= '0;
            scoremod <= '0;
        end else if (new_game) begin
            level    <= '0;
            sub      <= '0;
            scoremod <= '0;
        end else begin
            scoremod <= 25'(level) * STEP;
            if (lines_valid && level < MAXL) begin
                if (sum >= LPL) begin
                    level <= level + 4'd1;
                    sub   <= ((level + 4'd1) == MAXL) ? 4'd0 : 4'(sum - LPL);
                end else begin
                    sub <= sum[3:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            db_cnt   <= '0;
            speed_up <= 1'b0;
        end else begin
            sync1 <= down_btn;
            sync2 <= sync1;
            if (sync2 == speed_up) begin
                db_cnt <= '0;
            end else if (db_cnt == CW'(DEBOUNCE - 1)) begin
                speed_up <= ~speed_up;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // pending holds at most one extra tick; a simultaneous tick and ack swap old request for new
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            drop_req <= 1'b0;
            pending  <= 1'b0;
            overrun  <= 1'b0;
        end else if (new_game) begin
            state    <= IDLE;
            drop_req <= 1'b0;
            pending  <= 1'b0;
            overrun  <= 1'b0;
        end else if (game_over) begin
            state    <= IDLE;
            drop_req <= 1'b0;
            pending  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick_ev) begin
                        state    <= REQ;
                        drop_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (tick_ev && !drop_ack) begin
                        if (pending) overrun <= 1'b1;
                        else         pending <= 1'b1;
                    end else if (!tick_ev && drop_ack) begin
                        if (pending) begin
                            pending <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            drop_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    drop_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/t01_drop_pacer.md
Name: t01_drop_pacer

Overview:
- Control-side partner of the 1 Hz game-tick divider: computes the divider's `scoremod` and `speed_up` inputs and consumes its `newclk` output.
- `scoremod` is derived from cleared lines (level); `speed_up` is derived from the debounced soft-drop button.
- Converts each divider tick into a req/ack drop handshake toward the game FSM, with one-deep pending buffering and overrun detection.

Parameters:
- LINES_PER_LEVEL, 10: cleared lines needed per level increment (2..15).
- MAX_LEVEL, 15: level saturation value.
- LEVEL_STEP, 500000: `scoremod` increment per level; MAX_LEVEL*LEVEL_STEP must be <= 12000000.
- DEBOUNCE, 250000: consecutive equal synced samples needed to change `speed_up`.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- tick_n  in  1  divider `newclk`; idles high, one-cycle low pulse per period
- new_game  in  1  one-cycle pulse; restarts level/line state
- game_over  in  1  level; suppresses drop requests
- lines_valid  in  1  one-cycle strobe qualifying lines_cleared
- lines_cleared  in  3  lines cleared this strobe, 0..4 (5..7 treated as 4)
- down_btn  in  1  raw asynchronous soft-drop button
- drop_ack  in  1  game FSM has consumed the drop
- scoremod  out  25  level*LEVEL_STEP, to divider
- speed_up  out  1  debounced soft-drop, to divider
- level  out  4  current level
- drop_req  out  1  drop request, held until acked
- overrun  out  1  sticky: a tick arrived with a drop already pending

Behaviour:
- Reset values: all outputs 0. Internal state also resets: sync FFs 0, tick_prev 0, sub-line count 0, debounce count 0, pending 0, FSM IDLE.
- Tick detect:
  - tick_prev <= tick_n each cycle.
  - A tick event is tick_prev=1 & tick_n=0 (falling edge).
  - Because tick_prev resets to 0, the divider's reset-low `newclk` does not produce a false tick.
- Level counter:
  - On lines_valid, let s = sub + n.
  - If s >= LINES_PER_LEVEL and level < MAX_LEVEL: level+1, sub = s - LINES_PER_LEVEL.
  - Else if level < MAX_LEVEL: sub = s.
  - At MAX_LEVEL, sub holds at 0.
  - At most one level increment per strobe.
- scoremod:
  - Registered as level*LEVEL_STEP (25-bit, no overflow by parameter rule).
  - Valid one cycle after `level` changes.
- new_game: clears level, sub, scoremod, overrun, pending; FSM -> IDLE; drop_req 0 next cycle. It takes priority over lines_valid and ticks in the same cycle.
- speed_up:
  - down_btn passes through a 2-FF synchronizer.
  - The counter increments while the synced value differs from speed_up and resets to 0 when they are equal.
  - When the counter reaches DEBOUNCE-1 with the value still differing, speed_up toggles and the counter clears.
  - Glitches shorter than DEBOUNCE cycles are ignored.
- Drop FSM, states IDLE and REQ (drop_req = 1 exactly in REQ):
  - IDLE: a tick event with game_over=0 -> REQ on the next edge. Ticks with game_over=1 are dropped. drop_ack is ignored.
  - REQ: tick with pending=1 -> overrun <= 1 (excess tick discarded). Tick with pending=0 and no ack -> pending <= 1.
  - REQ + drop_ack, no tick: if pending, stay REQ and clear pending (back-to-back request); else -> IDLE.
  - REQ + drop_ack and tick in the same cycle: stay REQ; pending unchanged (the ack consumes the old request, the tick becomes the new one).
  - game_over=1 in any state: -> IDLE, pending cleared, drop_req 0 next cycle.
- Latency: a tick_n low sampled at edge k drives drop_req high after edge k+1 (one cycle of edge detect plus the FSM register).
- speed_up and scoremod update independently of FSM state.

Test Plan:
- Reset release with tick_n=0 then 1, then a low pulse 20 cycles later -> no drop_req from the reset phase; exactly one drop_req, rising 2 edges after the pulse.
- Parameters LINES_PER_LEVEL=10, LEVEL_STEP=500000: strobes of 4,4,3 lines -> level 1, sub 1, scoremod=500000. 44 further strobes of 4 lines -> level saturates at 15, scoremod=7500000.
- Two ticks without ack, then ack -> drop_req stays high through the ack, pending clears, overrun=0. A second ack -> IDLE. Three ticks without ack -> overrun=1 until new_game.
- DEBOUNCE=8: down_btn high for 5 cycles -> speed_up stays 0. Held high -> speed_up=1 after 8 stable synced cycles plus 2 sync cycles. Released -> 0 after the same delay.
- game_over=1 during REQ -> drop_req=0 next cycle; ticks ignored while it is high. new_game plus lines_valid in the same cycle -> level=0, scoremod=0.
